// File: rtl/overlay_ctrl.sv
// overlay_ctrl: frame-synchronous sequencer for the title/overlay sprite layer.
// Follows the game phase, drives the sprite enables, slides the "game over"
// banner in one step per frame, blinks the hint and gates restart requests
// until the banner has rested for HOLD_FRAMES frames.
//
// Handshake note: new_frame and button_pulse are single-cycle strobes with no
// back-pressure; each is consumed in the cycle it is high or dropped. All
// outputs are registered and reflect the state entered on the same clock edge.
module overlay_ctrl #(
  parameter int OVER_START_Y = -19,
  parameter int OVER_FINAL_Y = 52,
  parameter int OVER_STEP    = 4,
  parameter int HOLD_FRAMES  = 30,
  parameter int BLINK_HALF   = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        new_frame,
  input  logic [1:0]  phase,
  input  logic        button_pulse,
  output logic        logo_enable,
  output logic        ready_enable,
  output logic        hint_enable,
  output logic        over_enable,
  output logic [15:0] over_pos_y,
  output logic        btn_to_game,
  output logic        restart_pulse,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_TITLE = 3'd1,
    S_READY = 3'd2,
    S_PLAY  = 3'd3,
    S_DROP  = 3'd4,
    S_HOLD  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  localparam logic signed [16:0] START17 = 17'(OVER_START_Y);
  localparam logic signed [16:0] FINAL17 = 17'(OVER_FINAL_Y);
  localparam logic signed [16:0] STEP17  = 17'(OVER_STEP);
  localparam logic [15:0] START_Y    = 16'(OVER_START_Y);
  localparam logic [15:0] FINAL_Y    = 16'(OVER_FINAL_Y);
  localparam logic [15:0] HOLD_INIT  = 16'(HOLD_FRAMES);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

  // Game phase a state stands for; DROP/HOLD/WAIT all mean "over".
  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_TITLE: phase_of = 2'd0;
      S_READY: phase_of = 2'd1;
      S_PLAY:  phase_of = 2'd2;
      default: phase_of = 2'd3;
    endcase
  endfunction

  // Entry state for a game phase.
  function automatic state_t state_for(input logic [1:0] p);
    case (p)
      2'd0:    state_for = S_TITLE;
      2'd1:    state_for = S_READY;
      2'd2:    state_for = S_PLAY;
      default: state_for = S_DROP;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic [15:0] blink_cnt, blink_nxt;
  logic [15:0] hold_cnt, hold_nxt;
  logic [15:0] pos_nxt;
  logic        hint_nxt;
  logic        phase_change;
  logic        stay;
  logic signed [16:0] sum17;
  logic        logo_nxt, ready_nxt, over_nxt, btn_nxt, restart_nxt;

  assign state_dbg    = state;
  assign phase_change = (state != S_SYNC) && (phase_of(state) != phase);
  assign stay         = (state != S_SYNC) && !phase_change;
  assign sum17        = $signed({over_pos_y[15], over_pos_y}) + STEP17;

  // State register with the animation counters and banner position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_SYNC;
      blink_cnt   <= '0;
      hold_cnt    <= '0;
      over_pos_y  <= START_Y;
      hint_enable <= 1'b0;
    end else begin
      state       <= state_nxt;
      blink_cnt   <= blink_nxt;
      hold_cnt    <= hold_nxt;
      over_pos_y  <= pos_nxt;
      hint_enable <= hint_nxt;
    end
  end

  // Next state: a phase mismatch wins over frame steps in the same cycle.
  always_comb begin
    state_nxt = state;
    blink_nxt = blink_cnt;
    hold_nxt  = hold_cnt;
    pos_nxt   = over_pos_y;
    hint_nxt  = hint_enable;
    if (state == S_SYNC || phase_change) begin
      state_nxt = state_for(phase);
      blink_nxt = '0;
      hold_nxt  = '0;
      pos_nxt   = START_Y;
      hint_nxt  = (phase == 2'd1);
    end else if (new_frame) begin
      case (state)
        S_READY: begin
          if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
            hint_nxt  = ~hint_enable;
          end else begin
            blink_nxt = blink_cnt + 16'd1;
          end
        end
        S_DROP: begin
          if (sum17 >= FINAL17) begin
            pos_nxt   = FINAL_Y;
            state_nxt = S_HOLD;
            hold_nxt  = HOLD_INIT;
          end else begin
            pos_nxt = sum17[15:0];
          end
        end
        S_HOLD: begin
          if (hold_cnt <= 16'd1) begin
            hold_nxt  = '0;
            state_nxt = S_WAIT;
          end else begin
            hold_nxt = hold_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the state being entered; buttons pass only when staying.
  always_comb begin
    logo_nxt    = (state_nxt == S_TITLE);
    ready_nxt   = (state_nxt == S_READY);
    over_nxt    = (state_nxt == S_DROP) || (state_nxt == S_HOLD) ||
                  (state_nxt == S_WAIT);
    btn_nxt     = button_pulse && stay &&
                  ((state == S_TITLE) || (state == S_READY) || (state == S_PLAY));
    restart_nxt = button_pulse && stay && (state == S_WAIT);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      logo_enable   <= 1'b0;
      ready_enable  <= 1'b0;
      over_enable   <= 1'b0;
      btn_to_game   <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      logo_enable   <= logo_nxt;
      ready_enable  <= ready_nxt;
      over_enable   <= over_nxt;
      btn_to_game   <= btn_nxt;
      restart_pulse <= restart_nxt;
    end
  end

  // START17 documents the signed start value alongside FINAL17/STEP17.
  logic unused_start;
  assign unused_start = ^START17;

endmodule

// File: doc/overlay_ctrl.md
Name: overlay_ctrl

Overview:
Frame-synchronous sequencer for the title/overlay sprite layer. It follows the game phase and drives the enables for the logo, "get ready", hint and "game over" sprites. It animates the "game over" banner as a per-frame slide-in and blinks the hint. It also gates the button so a restart is accepted only after the game-over animation and a hold time finish. It sits between the game logic, the button pulse generator and the overlay sprite renderers in the top level.

Parameters:
OVER_START_Y, -19, signed initial banner y (hidden above screen)
OVER_FINAL_Y, 52, signed resting banner y
OVER_STEP, 4, y increment per frame during slide-in (>0)
HOLD_FRAMES, 30, frames the banner must rest before a restart is accepted
BLINK_HALF, 16, frames per hint on/off half-period

Ports:
clk  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
new_frame  in  1  one-cycle pulse at start of each frame
phase  in  2  game phase: 0 title, 1 ready, 2 playing, 3 over
button_pulse  in  1  one-cycle debounced button pulse
logo_enable  out  1  logo sprite enable
ready_enable  out  1  "get ready" sprite enable
hint_enable  out  1  hint sprite enable (blinking)
over_enable  out  1  "game over" sprite enable
over_pos_y  out  16  signed y position of "game over" banner
btn_to_game  out  1  button pulse forwarded to game logic
restart_pulse  out  1  one-cycle restart request

Behaviour:
- Reset is asynchronous and active-low. It applies on rstn low regardless of clk.
  - Resets to state SYNC.
  - All 1-bit outputs reset to 0; over_pos_y resets to OVER_START_Y.
  - Frame, blink and hold counters reset to 0.
- All outputs are registered. An output responds 1 cycle after the input event that causes it.
- States: SYNC, TITLE, READY, PLAY, DROP, HOLD, WAIT.
- SYNC: all outputs 0. Next cycle enters the state for the current phase (0→TITLE, 1→READY, 2→PLAY, 3→DROP).
- Phase-change rule: if phase differs from the phase the current state represents, enter the matching state next cycle.
  - DROP, HOLD and WAIT all represent phase 3.
  - A phase change aborts any animation in progress.
  - A phase change takes priority over new_frame and button_pulse in the same cycle; that cycle's animation step and button are discarded.
- TITLE: logo_enable=1; all other enables 0.
- READY: ready_enable=1.
  - On entry, blink counter=0 and hint_enable=1.
  - Each new_frame increments the blink counter. When it reaches BLINK_HALF-1, it wraps to 0 and hint_enable toggles.
- PLAY: all enables 0.
- DROP:
  - On entry, over_pos_y=OVER_START_Y and over_enable=1.
  - Each new_frame: over_pos_y = min(over_pos_y+OVER_STEP, OVER_FINAL_Y), computed as a signed 17-bit sum and then clamped.
  - When the clamped result equals OVER_FINAL_Y, go to HOLD with hold counter=HOLD_FRAMES.
- HOLD: over_enable=1. Each new_frame decrements the hold counter. When the counter reaches 0, go to WAIT.
- WAIT: over_enable=1.
  - button_pulse → restart_pulse=1 for exactly 1 cycle.
  - Further presses in WAIT each produce another restart_pulse.
  - The state remains WAIT until phase leaves 3.
- btn_to_game:
  - Equals button_pulse delayed 1 cycle in TITLE, READY and PLAY.
  - Forced 0 in SYNC, DROP, HOLD and WAIT.
  - restart_pulse and btn_to_game are never both 1 in the same cycle.
- Buttons during DROP and HOLD are dropped, not queued. A press in the same cycle as the HOLD→WAIT transition is ignored.
- If OVER_START_Y ≥ OVER_FINAL_Y, DROP clamps on its first frame and goes to HOLD.
- HOLD_FRAMES=0: HOLD exits on the first new_frame.
- Reset asserted mid-animation returns to SYNC and the reset values immediately; nothing is retained.

Test Plan:
- Reset low, then high with phase=0 → first cycle all outputs 0 (SYNC); next cycle logo_enable=1, over_pos_y=-19.
- phase=1, 40 new_frames → hint_enable starts 1; it toggles after new_frames 16 and 32; ready_enable stays 1.
- phase=3 then new_frames → over_pos_y sequence -19,-15,…,49,52. Clamp occurs on new_frame 18. HOLD lasts 30 frames, then WAIT.
- button_pulse during DROP and during HOLD → btn_to_game=0, restart_pulse=0. button_pulse in WAIT → restart_pulse high exactly 1 cycle, btn_to_game=0.
- phase=2 with button_pulse → btn_to_game pulse 1 cycle later. phase 3→0 mid-DROP (pos=-3) → next cycle over_enable=0, logo_enable=1.
- new_frame coincident with a phase change 2→3 → over_pos_y=-19 (no step). rstn low mid-HOLD → all outputs 0 at once, over_pos_y=-19.
